// File: rtl/sync_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between several clients.
// Define SYNC_ROM_ARB_OUT_REG_EN to add one register stage on the response outputs (latency 2).
module sync_rom_arbiter #(
  parameter int BusWidth      = 10,
  parameter int DataWidth     = 8,
  parameter int NumRequesters = 4,
  parameter int IdWidth       = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NumRequesters-1:0]          req_valid,
  input  logic [NumRequesters*BusWidth-1:0] req_address,
  output logic [NumRequesters-1:0]          req_ready,
  output logic [BusWidth-1:0]               rom_read_address,
  input  logic [DataWidth-1:0]              rom_data_out,
  output logic                              resp_valid,
  output logic [IdWidth-1:0]                resp_id,
  output logic [DataWidth-1:0]              resp_data
);
  localparam int PtrWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int SumWidth = PtrWidth + 1;

  logic [PtrWidth-1:0]      rr_ptr;
  logic [BusWidth-1:0]      last_address;
  logic [SumWidth-1:0]      scan_raw;
  logic [SumWidth-1:0]      scan_idx;
  logic                     hit;
  logic                     grant_any;
  logic [PtrWidth-1:0]      grant_idx;
  logic [NumRequesters-1:0] grant_vec;
  logic [BusWidth-1:0]      grant_address;
  logic                     granted_q;
  logic [IdWidth-1:0]       id_q;

  // Scan from rr_ptr upward with wrap; grants are suppressed while reset is held
  always_comb begin
    scan_raw  = '0;
    scan_idx  = '0;
    hit       = 1'b0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      scan_raw  = {1'b0, rr_ptr} + SumWidth'(k);
      scan_idx  = (scan_raw >= SumWidth'(NumRequesters)) ?
                  (scan_raw - SumWidth'(NumRequesters)) : scan_raw;
      hit       = rst_n && !grant_any && req_valid[scan_idx[PtrWidth-1:0]];
      grant_vec[scan_idx[PtrWidth-1:0]] = grant_vec[scan_idx[PtrWidth-1:0]] | hit;
      grant_idx = hit ? scan_idx[PtrWidth-1:0] : grant_idx;
      grant_any = grant_any | hit;
    end
  end

  // Select the granted client's address (grant_vec is one-hot or zero)
  always_comb begin
    grant_address = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      grant_address = grant_address |
                      ({BusWidth{grant_vec[i]}} & req_address[i*BusWidth +: BusWidth]);
    end
  end

  assign req_ready        = grant_vec;
  assign rom_read_address = grant_any ? grant_address : last_address;

  // Pointer advance, idle address hold and the "granted last cycle" response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      last_address <= '0;
      granted_q    <= 1'b0;
      id_q         <= '0;
    end else begin
      granted_q <= grant_any;
      id_q      <= IdWidth'(grant_idx);
      if (grant_any) begin
        rr_ptr       <= (grant_idx == PtrWidth'(NumRequesters - 1)) ? '0 : grant_idx + PtrWidth'(1);
        last_address <= grant_address;
      end
    end
  end

`ifdef SYNC_ROM_ARB_OUT_REG_EN
  logic                 valid_q2;
  logic [IdWidth-1:0]   id_q2;
  logic [DataWidth-1:0] data_q2;

  // Extra response stage; ROM word is captured in the cycle it arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q2 <= 1'b0;
      id_q2    <= '0;
      data_q2  <= '0;
    end else begin
      valid_q2 <= granted_q;
      id_q2    <= id_q;
      data_q2  <= rom_data_out;
    end
  end

  assign resp_valid = valid_q2;
  assign resp_id    = id_q2;
  assign resp_data  = data_q2;
`else
  assign resp_valid = granted_q;
  assign resp_id    = id_q;
  assign resp_data  = rom_data_out;
`endif

endmodule

// File: tb/tb_sync_rom_arbiter.sv
// Bench for sync_rom_arbiter: directed vector table, reset-in-flight sequence and
// randomized traffic against a behavioural arbitration/latency model.
module tb_sync_rom_arbiter;
  localparam int N  = 4;
  localparam int BW = 10;
`ifdef SYNC_ROM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*BW-1:0] req_address;
  logic [N-1:0]  req_ready;
  logic [BW-1:0] rom_read_address;
  logic [7:0]    rom_q;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [7:0]    resp_data;

  int compared   = 0;
  int mismatched = 0;

  sync_rom_arbiter #(.BusWidth(10), .DataWidth(8), .NumRequesters(4), .IdWidth(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_address(req_address),
    .req_ready(req_ready), .rom_read_address(rom_read_address), .rom_data_out(rom_q),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with word[a] = a[7:0] ^ 8'h5A
  always_ff @(posedge clk) rom_q <= rom_read_address[7:0] ^ 8'h5A;

  typedef struct {
    logic [3:0]  valid;
    logic [39:0] addr;
    logic [3:0]  exp_ready;
    logic [9:0]  exp_rom;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  typedef struct {
    logic       rv;
    logic [1:0] id;
    logic [7:0] data;
  } resp_t;

  vec_t  vecs[$];
  resp_t pend[$];

  int         m_ptr;
  logic [9:0] m_last;
  logic       hv[2];
  logic [1:0] hid[2];
  logic [9:0] haddr[2];
  int         waits[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [9:0] a3, input logic [9:0] a2,
                     input logic [9:0] a1, input logic [9:0] a0, input logic [3:0] rdy,
                     input logic [9:0] rom, input logic rv, input logic [1:0] id,
                     input logic [7:0] d);
    vec_t r;
    r.valid = v; r.addr = {a3, a2, a1, a0}; r.exp_ready = rdy; r.exp_rom = rom;
    r.exp_rv = rv; r.exp_id = id; r.exp_data = d;
    vecs.push_back(r);
  endtask

  task automatic model_check();
    int g;
    int wmax;
    logic [3:0] er;
    logic [9:0] erom;
    if (!rst_n) begin
      m_ptr = 0; m_last = '0;
      for (int i = 0; i < 2; i++) hv[i] = 1'b0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      check("rst_ready", {28'd0, req_ready}, 32'd0);
      check("rst_rom", {22'd0, rom_read_address}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_id", {30'd0, resp_id}, 32'd0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      er = 4'b0000;
      erom = m_last;
      if (g >= 0) begin
        er = 4'b0001 << g;
        erom = req_address[g*BW +: BW];
      end
      check("m_ready", {28'd0, req_ready}, {28'd0, er});
      check("m_rom", {22'd0, rom_read_address}, {22'd0, erom});
      check("m_resp_valid", {31'd0, resp_valid}, {31'd0, hv[LAT-1]});
      if (hv[LAT-1]) begin
        check("m_resp_id", {30'd0, resp_id}, {30'd0, hid[LAT-1]});
        check("m_resp_data", {24'd0, resp_data}, {24'd0, haddr[LAT-1][7:0] ^ 8'h5A});
      end
      wmax = 0;
      for (int i = 0; i < N; i++) begin
        waits[i] = (req_valid[i] && !req_ready[i]) ? waits[i] + 1 : 0;
        if (waits[i] > wmax) wmax = waits[i];
      end
      check("fairness", {31'd0, wmax < N}, 32'd1);
      hv[1] = hv[0]; hid[1] = hid[0]; haddr[1] = haddr[0];
      hv[0] = (g >= 0);
      if (g >= 0) begin
        hid[0] = 2'(g); haddr[0] = erom;
        m_ptr = (g + 1) % N; m_last = erom;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resp_t e;
    rst_n = 1'b0; req_valid = '0; req_address = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      #3; model_check(); advance();
    end
    rst_n = 1'b1;

    add(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000, 10'h000, 1'b0, 2'd0, 8'h00);
    for (int r = 0; r < 2; r++) begin
      add(4'b1111, 10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0, 4'b0001, 10'h2A0, 1'b1, 2'd0, 8'hFA);
      add(4'b1111, 10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0, 4'b0010, 10'h2A1, 1'b1, 2'd1, 8'hFB);
      add(4'b1111, 10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0, 4'b0100, 10'h2A2, 1'b1, 2'd2, 8'hF8);
      add(4'b1111, 10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0, 4'b1000, 10'h2A3, 1'b1, 2'd3, 8'hF9);
    end
    add(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000, 10'h2A3, 1'b0, 2'd0, 8'h00);
    add(4'b0100, 10'h0, 10'h013, 10'h0, 10'h0, 4'b0100, 10'h013, 1'b1, 2'd2, 8'h49);
    add(4'b1000, 10'h3FF, 10'h0, 10'h0, 10'h0, 4'b1000, 10'h3FF, 1'b1, 2'd3, 8'hA5);
    for (int r = 0; r < 5; r++)
      add(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000, 10'h3FF, 1'b0, 2'd0, 8'h00);
    add(4'b0010, 10'h0, 10'h0, 10'h055, 10'h0, 4'b0010, 10'h055, 1'b1, 2'd1, 8'h0F);
    for (int r = 0; r < 2; r++) begin
      add(4'b1010, 10'h033, 10'h0, 10'h011, 10'h0, 4'b1000, 10'h033, 1'b1, 2'd3, 8'h69);
      add(4'b1010, 10'h033, 10'h0, 10'h011, 10'h0, 4'b0010, 10'h011, 1'b1, 2'd1, 8'h4B);
    end
    add(4'b1011, 10'h033, 10'h0, 10'h011, 10'h0C0, 4'b1000, 10'h033, 1'b1, 2'd3, 8'h69);
    add(4'b1011, 10'h033, 10'h0, 10'h011, 10'h0C0, 4'b0001, 10'h0C0, 1'b1, 2'd0, 8'h9A);
    add(4'b0100, 10'h0, 10'h022, 10'h0, 10'h0, 4'b0100, 10'h022, 1'b1, 2'd2, 8'h78);
    add(4'b0011, 10'h0, 10'h0, 10'h021, 10'h020, 4'b0001, 10'h020, 1'b1, 2'd0, 8'h7A);
    add(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000, 10'h020, 1'b0, 2'd0, 8'h00);
    add(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000, 10'h020, 1'b0, 2'd0, 8'h00);

    for (int p = 0; p < LAT; p++) begin
      e.rv = 1'b0; e.id = 2'd0; e.data = 8'h00;
      pend.push_back(e);
    end
    for (int j = 0; j < vecs.size(); j++) begin
      req_valid = vecs[j].valid; req_address = vecs[j].addr;
      #3; model_check();
      check($sformatf("tbl_ready[%0d]", j), {28'd0, req_ready}, {28'd0, vecs[j].exp_ready});
      check($sformatf("tbl_rom[%0d]", j), {22'd0, rom_read_address}, {22'd0, vecs[j].exp_rom});
      e.rv = vecs[j].exp_rv; e.id = vecs[j].exp_id; e.data = vecs[j].exp_data;
      pend.push_back(e);
      if (pend.size() > LAT) begin
        e = pend.pop_front();
        check($sformatf("tbl_resp_valid[%0d]", j), {31'd0, resp_valid}, {31'd0, e.rv});
        if (e.rv) begin
          check($sformatf("tbl_resp_id[%0d]", j), {30'd0, resp_id}, {30'd0, e.id});
          check($sformatf("tbl_resp_data[%0d]", j), {24'd0, resp_data}, {24'd0, e.data});
        end
      end
      advance();
    end

    // Reset lands after an accept but before the edge that would register it
    req_valid = 4'b0001; req_address = {30'd0, 10'h077};
    #3; model_check();
    #1; rst_n = 1'b0;
    #1;
    check("t5_ready_async", {28'd0, req_ready}, 32'd0);
    check("t5_rom_async", {22'd0, rom_read_address}, 32'd0);
    advance();
    for (int c = 0; c < 3; c++) begin
      #3; model_check();
      check("t5_no_resp", {31'd0, resp_valid}, 32'd0);
      advance();
    end
    rst_n = 1'b1;
    req_valid = 4'b0101; req_address = {10'h0, 10'h0A2, 10'h0, 10'h0A1};
    #3; model_check();
    check("t5_first_grant", {28'd0, req_ready}, 32'd1);
    advance();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #3; model_check(); advance();
    end

    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_address[i*BW +: BW] = 10'($urandom);
      #3; model_check(); advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
